// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt-acknowledge initiator: FSM encoding,
// the 8080 CALL opcode and the per-mode pulse counts.
package pic_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLow  = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    localparam int unsigned PULSES_8086 = 2;
    localparam int unsigned PULSES_8080 = 3;

    // Index of the final INTA pulse for the latched mode.
    function automatic logic [1:0] last_pulse(input logic mode_8086);
        return mode_8086 ? 2'(PULSES_8086 - 1) : 2'(PULSES_8080 - 1);
    endfunction

endpackage

// File: rtl/inta_pulse_timer.sv
// Down-counter timing the LOW and GAP phases; terminal count is raised while
// the count sits at zero, so a load value of 0 gives a one-cycle phase.
module inta_pulse_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       tc_o
);

    logic [3:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign tc_o = (count_q == 4'd0);

endmodule

// File: rtl/inta_initiator.sv
// CPU-side interrupt-acknowledge sequencer: issues two (8086) or three (8080)
// INTA_N strobes, captures the PIC bytes and reports them with a VALID pulse.
module inta_initiator
    import pic_pkg::*;
#(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        INT,
    input  logic        EN,
    input  logic        MODE_8086,
    input  logic [7:0]  D_IN,
    output logic        INTA_N,
    output logic        BUSY,
    output logic [7:0]  VECTOR,
    output logic [15:0] CALL_ADDR,
    output logic        VALID,
    output logic        OPC_ERR
);

    localparam logic [3:0] PulseLoad = 4'(PULSE_W - 1);
    localparam logic [3:0] GapLoad   = 4'(GAP_W - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  pidx_q, pidx_d;
    logic        mode_q;
    logic [7:0]  byte0_q, byte1_q;
    logic [7:0]  vector_q;
    logic [15:0] call_addr_q;
    logic        opc_err_q;

    logic        tmr_load;
    logic [3:0]  tmr_val;
    logic        tmr_tc;
    logic        start;
    logic        sample;
    logic        last_low;

    inta_pulse_timer u_timer (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    assign start    = (state_q == StIdle) && INT && EN;
    assign sample   = (state_q == StLow) && tmr_tc;
    assign last_low = sample && (pidx_q == last_pulse(mode_q));

    always_comb begin
        state_d  = state_q;
        pidx_d   = pidx_q;
        tmr_load = 1'b0;
        tmr_val  = PulseLoad;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StLow;
                    pidx_d   = 2'd0;
                    tmr_load = 1'b1;
                end
            end
            StLow: begin
                if (last_low) begin
                    state_d = StDone;
                end else if (sample) begin
                    state_d  = StGap;
                    tmr_load = 1'b1;
                    tmr_val  = GapLoad;
                end
            end
            StGap: begin
                if (tmr_tc) begin
                    state_d  = StLow;
                    pidx_d   = pidx_q + 2'd1;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            pidx_q      <= 2'd0;
            mode_q      <= 1'b0;
            byte0_q     <= 8'h00;
            byte1_q     <= 8'h00;
            vector_q    <= 8'h00;
            call_addr_q <= 16'h0000;
            opc_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pidx_q  <= pidx_d;
            if (start) begin
                mode_q <= MODE_8086;
            end
            if (sample && pidx_q == 2'd0) begin
                byte0_q <= D_IN;
            end
            if (sample && pidx_q == 2'd1) begin
                byte1_q <= D_IN;
            end
            // Final byte is taken straight from the bus so results show with VALID.
            if (last_low) begin
                if (mode_q) begin
                    vector_q    <= D_IN;
                    call_addr_q <= 16'h0000;
                    opc_err_q   <= 1'b0;
                end else begin
                    vector_q    <= byte0_q;
                    call_addr_q <= {D_IN, byte1_q};
                    opc_err_q   <= (byte0_q != CALL_OPCODE);
                end
            end
        end
    end

    assign INTA_N    = (state_q != StLow);
    assign BUSY      = (state_q != StIdle);
    assign VALID     = (state_q == StDone);
    assign VECTOR    = vector_q;
    assign CALL_ADDR = call_addr_q;
    assign OPC_ERR   = opc_err_q;

endmodule

// File: tb/tb_inta_initiator.sv
// Directed bench for inta_initiator: default timing plus a PULSE_W=GAP_W=1 copy.
module tb_inta_initiator;

    logic        CLK;
    logic        RST_N;
    logic        INT;
    logic        EN;
    logic        MODE_8086;
    logic [7:0]  D_IN;
    logic        INTA_N, BUSY, VALID, OPC_ERR;
    logic [7:0]  VECTOR;
    logic [15:0] CALL_ADDR;
    logic        inta_n_m, busy_m, valid_m, opc_err_m;
    logic [7:0]  vector_m;
    logic [15:0] call_addr_m;

    int tests_run = 0;
    int fails     = 0;

    inta_initiator u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .INT       (INT),
        .EN        (EN),
        .MODE_8086 (MODE_8086),
        .D_IN      (D_IN),
        .INTA_N    (INTA_N),
        .BUSY      (BUSY),
        .VECTOR    (VECTOR),
        .CALL_ADDR (CALL_ADDR),
        .VALID     (VALID),
        .OPC_ERR   (OPC_ERR)
    );

    inta_initiator #(
        .PULSE_W (1),
        .GAP_W   (1)
    ) u_dut_min (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .INT       (INT),
        .EN        (EN),
        .MODE_8086 (MODE_8086),
        .D_IN      (D_IN),
        .INTA_N    (inta_n_m),
        .BUSY      (busy_m),
        .VECTOR    (vector_m),
        .CALL_ADDR (call_addr_m),
        .VALID     (valid_m),
        .OPC_ERR   (opc_err_m)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one request, feeds d0/d1/d2 on successive INTA_N lows and records
    // what the DUT reports; vcyc counts cycles after the request edge.
    task automatic run_seq(input logic mode, input logic toggle,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           output int vcyc, output int lows, output int pulses,
                           output logic [7:0] vec, output logic [15:0] call, output logic err);
        logic prev_n;
        MODE_8086 = mode;
        INT = 1'b1;
        EN = 1'b1;
        vcyc = -1;
        lows = 0;
        pulses = 0;
        prev_n = 1'b1;
        vec = 8'h00;
        call = 16'h0000;
        err = 1'b0;
        for (int k = 1; k <= 40 && vcyc < 0; k++) begin
            tick();
            if (k == 1) INT = 1'b0;
            if (toggle && k == 2) MODE_8086 = ~mode;
            if (INTA_N === 1'b0) begin
                lows++;
                if (prev_n) pulses++;
            end
            prev_n = INTA_N;
            D_IN = INTA_N ? 8'h5A : (pulses == 1 ? d0 : (pulses == 2 ? d1 : d2));
            if (VALID === 1'b1) begin
                vcyc = k;
                vec = VECTOR;
                call = CALL_ADDR;
                err = OPC_ERR;
            end
        end
        MODE_8086 = mode;
        D_IN = 8'h00;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        INT = 1'b1;
        EN = 1'b1;
        MODE_8086 = 1'b0;
        D_IN = 8'hA5;
        repeat (3) tick();
        tests_run++;
        if ({INTA_N, BUSY, VALID, OPC_ERR} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl: got {INTA_N,BUSY,VALID,OPC_ERR}=%b required 1000",
                     {INTA_N, BUSY, VALID, OPC_ERR});
        end
        tests_run++;
        if (VECTOR !== 8'h00 || CALL_ADDR !== 16'h0000) begin
            fails++;
            $display("FAIL reset_data: got VECTOR=%h CALL_ADDR=%h required 00/0000",
                     VECTOR, CALL_ADDR);
        end
        INT = 1'b0;
        RST_N = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_8086();
        int vcyc, lows, pulses;
        logic [7:0] vec;
        logic [15:0] call;
        logic err;
        run_seq(1'b1, 1'b0, 8'hFF, 8'h48, 8'h00, vcyc, lows, pulses, vec, call, err);
        tests_run++;
        if (vcyc !== 7 || pulses !== 2 || lows !== 4) begin
            fails++;
            $display("FAIL 8086_timing: got valid@%0d pulses=%0d lows=%0d required 7/2/4",
                     vcyc, pulses, lows);
        end
        tests_run++;
        if (vec !== 8'h48 || call !== 16'h0000 || err !== 1'b0) begin
            fails++;
            $display("FAIL 8086_data: got vec=%h call=%h err=%b required 48/0000/0",
                     vec, call, err);
        end
        repeat (5) tick();
        tests_run++;
        if (VECTOR !== 8'h48 || VALID !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL 8086_hold: got VECTOR=%h VALID=%b BUSY=%b required 48/0/0",
                     VECTOR, VALID, BUSY);
        end
    endtask

    task automatic test_8080();
        int vcyc, lows, pulses;
        logic [7:0] vec;
        logic [15:0] call;
        logic err;
        run_seq(1'b0, 1'b0, 8'hCD, 8'h20, 8'h00, vcyc, lows, pulses, vec, call, err);
        tests_run++;
        if (vcyc !== 11 || pulses !== 3 || lows !== 6) begin
            fails++;
            $display("FAIL 8080_timing: got valid@%0d pulses=%0d lows=%0d required 11/3/6",
                     vcyc, pulses, lows);
        end
        tests_run++;
        if (vec !== 8'hCD || call !== 16'h0020 || err !== 1'b0) begin
            fails++;
            $display("FAIL 8080_data: got vec=%h call=%h err=%b required CD/0020/0",
                     vec, call, err);
        end
        repeat (3) tick();
        run_seq(1'b0, 1'b0, 8'h00, 8'h20, 8'h00, vcyc, lows, pulses, vec, call, err);
        tests_run++;
        if (vcyc !== 11 || vec !== 8'h00 || call !== 16'h0020 || err !== 1'b1) begin
            fails++;
            $display("FAIL 8080_opc_err: got valid@%0d vec=%h call=%h err=%b required 11/00/0020/1",
                     vcyc, vec, call, err);
        end
        repeat (3) tick();
    endtask

    task automatic test_mode_toggle();
        int vcyc, lows, pulses;
        logic [7:0] vec;
        logic [15:0] call;
        logic err;
        run_seq(1'b0, 1'b1, 8'hCD, 8'h34, 8'h12, vcyc, lows, pulses, vec, call, err);
        tests_run++;
        if (vcyc !== 11 || pulses !== 3) begin
            fails++;
            $display("FAIL toggle_timing: got valid@%0d pulses=%0d required 11/3", vcyc, pulses);
        end
        tests_run++;
        if (vec !== 8'hCD || call !== 16'h1234 || err !== 1'b0) begin
            fails++;
            $display("FAIL toggle_data: got vec=%h call=%h err=%b required CD/1234/0",
                     vec, call, err);
        end
        repeat (3) tick();
    endtask

    task automatic test_enable_gate();
        int vcyc;
        MODE_8086 = 1'b1;
        INT = 1'b1;
        EN = 1'b0;
        D_IN = 8'h77;
        for (int k = 0; k < 20; k++) begin
            tick();
            tests_run++;
            if (INTA_N !== 1'b1 || BUSY !== 1'b0) begin
                fails++;
                $display("FAIL en_gate[%0d]: got INTA_N=%b BUSY=%b required 1/0", k, INTA_N, BUSY);
            end
        end
        EN = 1'b1;
        tick();
        tests_run++;
        if (INTA_N !== 1'b0 || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL en_start: got INTA_N=%b BUSY=%b required 0/1", INTA_N, BUSY);
        end
        INT = 1'b0;
        vcyc = -1;
        for (int k = 2; k <= 20 && vcyc < 0; k++) begin
            tick();
            if (VALID === 1'b1) vcyc = k;
        end
        tests_run++;
        if (vcyc !== 7 || VECTOR !== 8'h77) begin
            fails++;
            $display("FAIL en_seq: got valid@%0d VECTOR=%h required 7/77", vcyc, VECTOR);
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int v1, v2, pulses;
        logic [7:0] vec1, vec2;
        logic busy8, inta9, prev_n;
        MODE_8086 = 1'b1;
        INT = 1'b1;
        EN = 1'b1;
        v1 = -1;
        v2 = -1;
        pulses = 0;
        prev_n = 1'b1;
        vec1 = 8'h00;
        vec2 = 8'h00;
        busy8 = 1'bx;
        inta9 = 1'bx;
        for (int k = 1; k <= 30 && v2 < 0; k++) begin
            tick();
            if (k == 9) INT = 1'b0;
            if (INTA_N === 1'b0 && prev_n) pulses++;
            prev_n = INTA_N;
            D_IN = INTA_N ? 8'h5A : 8'(8'h60 + pulses);
            if (k == 8) busy8 = BUSY;
            if (k == 9) inta9 = INTA_N;
            if (VALID === 1'b1) begin
                if (v1 < 0) begin
                    v1 = k;
                    vec1 = VECTOR;
                end else begin
                    v2 = k;
                    vec2 = VECTOR;
                end
            end
        end
        tests_run++;
        if (v1 !== 7 || v2 !== 15) begin
            fails++;
            $display("FAIL b2b_timing: got valid@%0d,%0d required 7,15", v1, v2);
        end
        tests_run++;
        if (busy8 !== 1'b0 || inta9 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_gap: got BUSY@8=%b INTA_N@9=%b required 0/0", busy8, inta9);
        end
        tests_run++;
        if (vec1 !== 8'h62 || vec2 !== 8'h64) begin
            fails++;
            $display("FAIL b2b_data: got vec=%h,%h required 62,64", vec1, vec2);
        end
        D_IN = 8'h00;
        repeat (4) tick();
    endtask

    task automatic test_min_timing();
        logic [4:0] exp_n, exp_v;
        exp_n = 5'b11010;
        exp_v = 5'b01000;
        MODE_8086 = 1'b1;
        INT = 1'b1;
        EN = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) INT = 1'b0;
            D_IN = 8'(8'h30 + k);
            tests_run++;
            if (inta_n_m !== exp_n[k-1] || valid_m !== exp_v[k-1]) begin
                fails++;
                $display("FAIL min_wave[%0d]: got INTA_N=%b VALID=%b required %b/%b",
                         k, inta_n_m, valid_m, exp_n[k-1], exp_v[k-1]);
            end
        end
        tests_run++;
        if (vector_m !== 8'h33 || call_addr_m !== 16'h0000 || opc_err_m !== 1'b0) begin
            fails++;
            $display("FAIL min_data: got vec=%h call=%h err=%b required 33/0000/0",
                     vector_m, call_addr_m, opc_err_m);
        end
        D_IN = 8'h00;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid();
        MODE_8086 = 1'b1;
        INT = 1'b1;
        EN = 1'b1;
        D_IN = 8'h99;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) INT = 1'b0;
        end
        tests_run++;
        if (INTA_N !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_pre: got INTA_N=%b required 0 in second LOW", INTA_N);
        end
        RST_N = 1'b0;
        tick();
        tests_run++;
        if (INTA_N !== 1'b1 || BUSY !== 1'b0 || VALID !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_ctrl: got INTA_N=%b BUSY=%b VALID=%b required 1/0/0",
                     INTA_N, BUSY, VALID);
        end
        tests_run++;
        if (VECTOR !== 8'h00 || CALL_ADDR !== 16'h0000 || OPC_ERR !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_data: got VECTOR=%h CALL_ADDR=%h OPC_ERR=%b required 00/0000/0",
                     VECTOR, CALL_ADDR, OPC_ERR);
        end
        RST_N = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++;
            if (VALID !== 1'b0 || BUSY !== 1'b0) begin
                fails++;
                $display("FAIL rst_mid_after[%0d]: got VALID=%b BUSY=%b required 0/0",
                         k, VALID, BUSY);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        INT = 1'b0;
        EN = 1'b0;
        MODE_8086 = 1'b0;
        D_IN = 8'h00;
        #1;
        test_reset();
        test_8086();
        test_8080();
        test_mode_toggle();
        test_enable_gate();
        test_back_to_back();
        test_min_timing();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/inta_initiator.md
INTA_INITIATOR -- requirements
Module: inta_initiator

Interface
REQ-001 Parameter PULSE_W, default 2, cycles INTA_N held low per pulse; legal range 1..15.
REQ-002 Parameter GAP_W, default 2, cycles INTA_N held high between pulses; legal range 1..15.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 INT  input  1  interrupt request from the PIC, level, synchronous to CLK.
REQ-006 EN  input  1  CPU interrupt-enable flag; 1 permits a new acknowledge sequence.
REQ-007 MODE_8086  input  1  1 = two-pulse 8086 sequence; 0 = three-pulse 8080 CALL sequence.
REQ-008 D_IN  input  8  PIC data bus, valid while INTA_N is low.
REQ-009 INTA_N  output  1  interrupt-acknowledge strobe to the PIC, active-low.
REQ-010 BUSY  output  1  high whenever the state machine is not IDLE.
REQ-011 VECTOR  output  8  captured vector (8086) or captured opcode byte (8080).
REQ-012 CALL_ADDR  output  16  captured call address in 8080 mode; 16'h0000 in 8086 mode.
REQ-013 VALID  output  1  one-cycle pulse marking VECTOR/CALL_ADDR/OPC_ERR updated.
REQ-014 OPC_ERR  output  1  high with VALID when the 8080 first byte is not 8'hCD.

Function
REQ-015 States SHALL be IDLE, LOW, GAP, DONE; a pulse index (0..2) and a 4-bit cycle counter SHALL qualify LOW and GAP.
REQ-016 In IDLE with INT=1 and EN=1 at an edge, the next state SHALL be LOW with pulse index 0; MODE_8086 SHALL be latched at that edge.
REQ-017 INT and EN SHALL be ignored outside IDLE; a started sequence always completes.
REQ-018 INTA_N SHALL be 0 exactly in LOW and 1 in every other state.
REQ-019 LOW SHALL last PULSE_W cycles; D_IN SHALL be sampled on the last LOW cycle into the byte slot given by the pulse index.
REQ-020 After LOW for a non-final pulse, state SHALL go to GAP for GAP_W cycles, then LOW with the pulse index incremented.
REQ-021 Final pulse is index 1 in 8086 mode and index 2 in 8080 mode; after its LOW the state SHALL go to DONE.
REQ-022 DONE SHALL last one cycle with VALID=1, then return to IDLE.
REQ-023 8086 mode: byte 0 SHALL be discarded; VECTOR = byte 1; CALL_ADDR = 16'h0000; OPC_ERR = 0.
REQ-024 8080 mode: VECTOR = byte 0; CALL_ADDR = {byte 2, byte 1}; OPC_ERR = (byte 0 != 8'hCD).
REQ-025 VECTOR, CALL_ADDR and OPC_ERR SHALL update only on the DONE cycle and hold between sequences.
REQ-026 IDLE SHALL last at least one cycle after DONE; INT still high there SHALL start a new sequence on the next edge.
REQ-027 Total latency, request edge to VALID: 2*PULSE_W+GAP_W+1 cycles (8086) and 3*PULSE_W+2*GAP_W+1 cycles (8080).
REQ-028 With PULSE_W=1 and GAP_W=1, the sample and the exit transition SHALL occur on the same LOW cycle.

Reset
REQ-029 RST_N=0 at an edge SHALL force IDLE, INTA_N=1, BUSY=0, VALID=0, OPC_ERR=0, VECTOR=8'h00, CALL_ADDR=16'h0000, and clear counters.
REQ-030 Reset mid-sequence SHALL abort without a VALID pulse; INTA_N SHALL be 1 from the edge at which reset is sampled.
REQ-031 Reset SHALL take priority over every other input.

Structure
REQ-032 Shared package pic_pkg SHALL hold the state encoding, CALL_OPCODE=8'hCD, and the pulse counts (2 and 3).
REQ-033 One sub-module, inta_pulse_timer (load/count/terminal-count for PULSE_W and GAP_W), SHALL be instantiated.

Verification
REQ-034 8086, defaults: INT=1, EN=1, D_IN=8'hFF on pulse 0 and 8'h48 on pulse 1 -> two 2-cycle INTA_N lows, VALID at cycle 7, VECTOR=8'h48, CALL_ADDR=0.
REQ-035 8080: D_IN 8'hCD, 8'h20, 8'h00 -> three pulses, VALID at cycle 11, VECTOR=8'hCD, CALL_ADDR=16'h0020, OPC_ERR=0.
REQ-036 8080 with first byte 8'h00 -> VALID with OPC_ERR=1.
REQ-037 EN=0 with INT=1 for 20 cycles -> INTA_N stays 1, BUSY=0; EN raised -> sequence starts on the next edge.
REQ-038 RST_N=0 during the second LOW -> INTA_N=1 at that edge, no VALID, outputs at reset values.
REQ-039 INT held high across DONE -> one IDLE cycle, then a second sequence; MODE_8086 toggled mid-sequence -> no effect on the current sequence.
